uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
UART receive stage of the Wishbone UART peripheral. Takes the asynchronous serial line from the user-project I/O pad (mprj_io[15]) and deserialises 8N1 frames using a programmable baud divisor; for example, 434 at 50 MHz gives 115200 baud. Received bytes are buffered in a small FIFO. The Wishbone register block pops them through a valid/ready handshake. Status flags report line errors.

Parameters:
FIFO_DEPTH, 8, FIFO entries; power of two, at least 2.
DIV_W, 16, width of the baud divisor input.

Ports:
wb_clk_i  input  1  system clock. One clock for the whole block.
wb_rst_n  input  1  reset; asynchronous assert, active-low.
en  input  1  receiver enable.
baud_div  input  DIV_W  clock cycles per bit.
rx_i  input  1  serial line from the pad; asynchronous, idle high.
rx_data  output  8  FIFO head byte.
rx_valid  output  1  FIFO non-empty.
rx_ready  input  1  consumer pop strobe; a pop occurs when rx_valid && rx_ready.
fifo_level  output  $clog2(FIFO_DEPTH)+1  number of bytes held in the FIFO.
rx_busy  output  1  a frame is in progress (FSM not IDLE).
frame_err  output  1  sticky: stop bit was sampled 0.
overrun  output  1  sticky: a byte was dropped because the FIFO was full.
err_clr  input  1  one-cycle pulse that clears frame_err and overrun.

Behaviour:
- Reset values: all outputs 0 (rx_data 8'h00, rx_valid 0, fifo_level 0, rx_busy 0, frame_err 0, overrun 0). FSM goes to IDLE, the FIFO is emptied, and the synchroniser flops are set to 1.
- Reset mid-frame aborts the frame with no push and no flag change.
- Input path: rx_i passes through a 2-FF synchroniser to give rx_s. A third flop holds rx_s_d for edge detection. The latency from pad to FSM is 2 cycles.
- Divisor latch: baud_div is latched into div_q when the start edge is detected. Changes to baud_div during a frame have no effect on that frame. Latched values below 2 are replaced by 2.
- Bit counter: bit_cnt is DIV_W bits wide and counts down. A reload means bit_cnt = div_q-1, or (div_q>>1)-1 for the half-bit reload in START.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when en=1 and a falling edge is seen (rx_s_d=1, rx_s=0), latch the divisor, load the half-bit count and go to START.
  - START: when the count reaches 0, sample rx_s.
    - rx_s=1: false start; go to IDLE with no flags.
    - rx_s=0: load the full-bit count, set bit_idx=0 and go to DATA.
  - DATA: at each count expiry, sample rx_s into shift[bit_idx] (LSB first), increment bit_idx and reload the count. After bit_idx 7 is sampled, go to STOP.
  - STOP: at count expiry, sample rx_s and return to IDLE.
    - rx_s=1: push the byte.
    - rx_s=0: set frame_err; the byte is discarded.
- Sample timing: each bit is sampled at its midpoint. A complete frame pushes its byte about 9.5*div_q+3 cycles after the falling edge on rx_i.
- Enable: en=0 forces IDLE in the next cycle and aborts any frame in progress. FIFO contents and flags are kept.
- FIFO behaviour:
  - First-word-fall-through: rx_data always shows the head entry when rx_valid=1.
  - A push becomes visible on rx_valid and fifo_level one cycle after the push.
  - fifo_level: +1 on a push alone, -1 on a pop alone, unchanged on a simultaneous push and pop.
  - Pointers wrap modulo FIFO_DEPTH.
- Full FIFO:
  - A push with no pop in the same cycle drops the byte and sets overrun.
  - A push with a pop in the same cycle is accepted; the level stays at FIFO_DEPTH and overrun is not set.
- Empty FIFO: rx_ready is ignored and rx_data holds its last value.
- Flag set/clear priority: if err_clr and a flag-set event fall in the same cycle, the set wins and the flag stays 1.
- rx_busy = (state != IDLE).

Decomposition:
- Package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, STOP).
  - UART_DATA_BITS = 8.
  - UART_DIV_MIN = 2.
  - UART_DEF_DIV_50M_115200 = 434.
- One sub-module, sync_fifo (parameters WIDTH and DEPTH), which provides push/pop/full/empty/level and first-word-fall-through output.
- The FSM, synchroniser, bit counter and flags live in uart_rx_fifo.

Test Plan:
- Single byte: baud_div=434, en=1, drive 8'hA5 on rx_i as 8N1. Expect rx_valid=1 with rx_data=8'hA5 and fifo_level=1 within 9.5*434+4 cycles; pulse rx_ready and expect rx_valid=0 next cycle.
- Glitch: rx_i low for 100 cycles then high, with baud_div=434. Expect no push, FSM back in IDLE after 217 cycles, frame_err=0.
- Framing error: send 8'h3C with the stop bit held 0. Expect frame_err=1 and fifo_level=0. Pulse err_clr and expect frame_err=0 next cycle.
- Overrun: hold rx_ready=0 and send 9 bytes 8'h01..8'h09. Expect fifo_level=8 and overrun=1. Then pop to read 01..08 in order, after which rx_valid=0.
- Full with simultaneous pop: with the FIFO holding 8 bytes, assert rx_ready in the exact cycle the 9th byte pushes. Expect level 8, overrun=0, and 8'h09 at the tail.
- Reset/enable abort: drop wb_rst_n, or drop en, in the middle of the DATA bits. Expect no push and rx_busy=0. A following clean byte 8'h5A is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int unsigned UART_DATA_BITS          = 8;
  localparam int unsigned UART_DIV_MIN            = 2;
  localparam int unsigned UART_DEF_DIV_50M_115200 = 434;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Received-byte handshake between the UART receiver and the register block.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  logic [7:0]                    rx_data;
  logic                          rx_valid;
  logic                          rx_ready;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;

  modport master (output rx_data, output rx_valid, output fifo_level, input rx_ready);
  modport slave  (input rx_data, input rx_valid, input fifo_level, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through FIFO; head output holds its last value while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_hold;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == LW'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_level   = r_level;
  assign o_data    = o_empty ? r_hold : r_mem[r_rd];

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_hold  <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      if (!o_empty)  r_hold <= r_mem[r_rd];
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with programmable divisor, receive FIFO and sticky error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              en,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              rx_i,
  output logic              rx_busy,
  output logic              frame_err,
  output logic              overrun,
  input  logic              err_clr,
  uart_rx_fifo_if.master    rx_if
);
  localparam int IDXW = $clog2(UART_DATA_BITS);

  logic             r_rx_meta, r_rx_s, r_rx_s_d;
  rx_state_t        r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div_q, r_cnt, w_div_eff;
  logic [IDXW-1:0]  r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_frame_err, r_overrun;
  logic             w_latch, w_load_full, w_sample, w_push, w_frame_set;
  logic             w_cnt_zero, w_fall, w_pop, w_full, w_empty;

  assign w_div_eff  = (baud_div < DIV_W'(UART_DIV_MIN)) ? DIV_W'(UART_DIV_MIN) : baud_div;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_fall     = r_rx_s_d & ~r_rx_s;
  assign w_pop      = rx_if.rx_valid & rx_if.rx_ready;
  assign rx_busy    = (r_state != IDLE);
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign rx_if.rx_valid = ~w_empty;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_s_d  <= 1'b1;
      r_state   <= IDLE;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_s    <= r_rx_meta;
      r_rx_s_d  <= r_rx_s;
      r_state   <= w_state_nxt;
    end
  end

  // Strobes are only raised while enabled, so dropping en aborts without a push.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_load_full = 1'b0;
    w_sample    = 1'b0;
    w_push      = 1'b0;
    w_frame_set = 1'b0;
    if (!en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_fall) begin
          w_latch     = 1'b1;
          w_state_nxt = START;
        end
        START: if (w_cnt_zero) begin
          if (r_rx_s) begin
            w_state_nxt = IDLE;
          end else begin
            w_load_full = 1'b1;
            w_state_nxt = DATA;
          end
        end
        DATA: if (w_cnt_zero) begin
          w_sample    = 1'b1;
          w_load_full = 1'b1;
          if (r_bit_idx == IDXW'(UART_DATA_BITS - 1)) w_state_nxt = STOP;
        end
        STOP: if (w_cnt_zero) begin
          w_state_nxt = IDLE;
          if (r_rx_s) w_push = 1'b1;
          else        w_frame_set = 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_div_q     <= '0;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_latch) begin
        r_div_q   <= w_div_eff;
        r_cnt     <= (w_div_eff >> 1) - 1'b1;
        r_bit_idx <= '0;
      end else if (w_load_full) begin
        r_cnt <= r_div_q - 1'b1;
      end else if (!w_cnt_zero) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_sample) begin
        r_shift[r_bit_idx] <= r_rx_s;
        r_bit_idx          <= r_bit_idx + 1'b1;
      end
      if (w_frame_set)                   r_frame_err <= 1'b1;
      else if (err_clr)                  r_frame_err <= 1'b0;
      if (w_push && w_full && !w_pop)    r_overrun   <= 1'b1;
      else if (err_clr)                  r_overrun   <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_n),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (rx_if.rx_ready),
    .o_data  (rx_if.rx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (rx_if.fifo_level)
  );

endmodule
